cache_2way_wb: RTL and testbench
================================

# cache_2way_wb

Parametrised two-way set-associative, write-back, write-allocate cache with true per-set LRU replacement and a request/acknowledge memory port. It sits between the processor datapath load/store unit and main memory. It replaces the single-cycle fixed-size cache with a latency-tolerant controller that stalls the requester through `req_ready` while it writes back dirty victims and fills missed lines.

## Interface
- `ADDR_W`, 8, byte-free word address width.
- `DATA_W`, 16, data word width; one word per line.
- `INDEX_W`, 2, set index width; sets = 2^INDEX_W; tag width TAG_W = ADDR_W − INDEX_W (must be ≥ 1).
- `CNT_W`, 16, width of the statistics counters.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: cache can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: index = `[INDEX_W-1:0]`, tag = `[ADDR_W-1:INDEX_W]`.
- `req_wdata` in DATA_W: store data.
- `resp_valid` out 1: one-cycle pulse, request completed.
- `resp_rdata` out DATA_W: load data, valid with `resp_valid`; stores return the written word.
- `resp_hit` out 1: 1 = hit, 0 = miss; valid with `resp_valid`.
- `mem_req` out 1: memory transaction active.
- `mem_we` out 1: 1 = write-back, 0 = fill read.
- `mem_addr` out ADDR_W: line address.
- `mem_wdata` out DATA_W: victim data.
- `mem_ack` in 1: memory completes the current transaction; sampled on the rising edge.
- `mem_rdata` in DATA_W: fill data, valid with `mem_ack` when `mem_we`=0.
- `hit_cnt`, `miss_cnt`, `wb_cnt` out CNT_W each: saturating event counters.

## Operation
- Per way and set: data, tag, valid, dirty. Per set: `lru` bit, which names the least-recently-used way.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
- IDLE: `req_ready`=1. When `req_valid` is high, latch write, addr and wdata, then go to LOOKUP. Inputs are ignored outside IDLE.
- LOOKUP: hit when valid and tag match. If both ways match, way0 wins; this cannot occur in normal operation.
  - Load hit: capture the data.
  - Store hit: write the data, set dirty.
  - Any hit: set `lru[set]` to the way not used, increment `hit_cnt`, go to RESP.
  - Miss: pick the victim. The first invalid way is chosen (way0 before way1); otherwise the way named by `lru[set]`. Increment `miss_cnt`.
  - Victim valid and dirty: go to WB. Otherwise go to FILL.
- WB: drive `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim data. On `mem_ack`: increment `wb_cnt`, go to FILL.
- FILL: drive `mem_req`=1, `mem_we`=0, `mem_addr`=latched addr. On `mem_ack`, install the line in the victim way:
  - tag = request tag, valid = 1.
  - Load: data = `mem_rdata`, dirty = 0, and `resp_rdata` = `mem_rdata`.
  - Store: data = latched wdata, dirty = 1.
  - Set `lru[set]` to the other way, then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Counters stop at 2^CNT_W − 1 and do not wrap.
- `mem_ack` is ignored in IDLE, LOOKUP and RESP.

## Timing
- Reset (async assert): state=IDLE.
  - Output values: `req_ready`=1, `resp_valid`=0, `resp_hit`=0, `resp_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, all counters 0.
  - Cleared arrays: all valid, dirty and lru bits. Data and tag arrays are not reset.
- Reset mid-transaction aborts immediately; `mem_req` drops asynchronously. No partial install occurs.
- Hit latency: accepted at edge E0 → LOOKUP → `resp_valid` high between E1 and E2 → `req_ready` high again after E2. Peak throughput is one request per 3 cycles.
- Clean miss: `mem_req` rises after E1. If `mem_ack` is sampled at edge Ek, `resp_valid` is high between Ek and Ek+1.
- Dirty miss: the WB transaction completes first. FILL's `mem_req` starts on the edge that samples the WB ack, with no idle cycle between.
- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and held stable until `mem_ack` is sampled high.
  - `mem_req` deasserts the cycle after ack, except WB→FILL, where it stays high and only `mem_we` and `mem_addr` change.
  - Zero-wait ack (ack in the first `mem_req` cycle) must work.
- `resp_rdata` and `resp_hit` hold their last value outside `resp_valid`.

## Test plan
(ADDR_W=8, INDEX_W=2.)
- Reset, then load 0x05, memory returns 0xBEEF after 3 wait cycles → one `mem_req` read at 0x05. Response: `resp_hit`=0, `resp_rdata`=0xBEEF, `miss_cnt`=1.
- Repeat load 0x05 → no `mem_req`. `resp_valid` 2 edges after accept with `resp_hit`=1, `resp_rdata`=0xBEEF, `hit_cnt`=1.
- Store 0x1234 to 0x05 (hit), then load 0x09 and load 0x0D (same set 1, different tags) → the 0x0D miss evicts LRU way of 0x05. Expect a write-back at `mem_addr`=0x05 with `mem_wdata`=0x1234, then a fill at 0x0D, with `wb_cnt`=1.
- LRU order: fill 0x02 and 0x06, then load 0x02 (hit), then load 0x0A → victim is the 0x06 way. A subsequent load of 0x02 hits.
- Store miss to 0x03 with clean victim → fill read at 0x03. Response `resp_rdata`=`req_wdata`, line is dirty, and later eviction writes it back.
- Assert `rst_n`=0 while `mem_req`=1 in WB with `mem_ack` held low → `mem_req`=0 immediately. After release, load of the same address misses (`valid` cleared) and counters read 0.

Source files
------------

// File: rtl/cache_2way_wb.sv
// rtl/cache_2way_wb.sv - two-way set-associative write-back, write-allocate cache
// with per-set LRU replacement and a request/acknowledge memory port.
module cache_2way_wb #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int INDEX_W = 2,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt,
   output logic [CNT_W-1:0]  wb_cnt
);

   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int SETS  = 1 << INDEX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

   state_t            state;
   logic              lat_write;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              victim;

   logic [DATA_W-1:0] data_q  [2][SETS];
   logic [TAG_W-1:0]  tag_q   [2][SETS];
   logic [SETS-1:0]   valid_q [2];
   logic [SETS-1:0]   dirty_q [2];
   logic [SETS-1:0]   lru_q;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tg;
   logic               hit0, hit1, hit, hit_way, miss_victim;

   assign idx     = lat_addr[INDEX_W-1:0];
   assign tg      = lat_addr[ADDR_W-1:INDEX_W];
   assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tg);
   assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tg);
   assign hit     = hit0 || hit1;
   assign hit_way = hit0 ? 1'b0 : 1'b1;
   // Empty ways are filled before anything is evicted.
   assign miss_victim = !valid_q[0][idx] ? 1'b0 :
                        !valid_q[1][idx] ? 1'b1 : lru_q[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_rdata <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         wb_cnt     <= '0;
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         victim     <= 1'b0;
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         dirty_q[0] <= '0;
         dirty_q[1] <= '0;
         lru_q      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  req_ready <= 1'b0;
                  state     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  if (lat_write) begin
                     data_q[hit_way][idx]  <= lat_wdata;
                     dirty_q[hit_way][idx] <= 1'b1;
                     resp_rdata            <= lat_wdata;
                  end else begin
                     resp_rdata <= data_q[hit_way][idx];
                  end
                  lru_q[idx] <= ~hit_way;
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b1;
                  if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_W'(1);
                  state <= S_RESP;
               end else begin
                  victim  <= miss_victim;
                  mem_req <= 1'b1;
                  if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
                  if (valid_q[miss_victim][idx] && dirty_q[miss_victim][idx]) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= {tag_q[miss_victim][idx], idx};
                     mem_wdata <= data_q[miss_victim][idx];
                     state     <= S_WB;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= lat_addr;
                     state    <= S_FILL;
                  end
               end
            end
            S_WB: begin
               // mem_req stays high so the fill follows the write-back back-to-back.
               if (mem_ack) begin
                  if (wb_cnt != CNT_MAX) wb_cnt <= wb_cnt + CNT_W'(1);
                  mem_we   <= 1'b0;
                  mem_addr <= lat_addr;
                  state    <= S_FILL;
               end
            end
            S_FILL: begin
               if (mem_ack) begin
                  tag_q[victim][idx]   <= tg;
                  valid_q[victim][idx] <= 1'b1;
                  if (lat_write) begin
                     data_q[victim][idx]  <= lat_wdata;
                     dirty_q[victim][idx] <= 1'b1;
                     resp_rdata           <= lat_wdata;
                  end else begin
                     data_q[victim][idx]  <= mem_rdata;
                     dirty_q[victim][idx] <= 1'b0;
                     resp_rdata           <= mem_rdata;
                  end
                  lru_q[idx] <= ~victim;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b0;
                  state      <= S_RESP;
               end
            end
            S_RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_2way_wb.sv
// tb/tb_cache_2way_wb.sv - randomized bench for cache_2way_wb against a recency-list
// cache model and a latency-randomized memory responder.
module tb_cache_2way_wb;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_write;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid, resp_hit;
   logic [15:0] resp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [15:0] hit_cnt, miss_cnt, wb_cnt;

   cache_2way_wb #(.ADDR_W(8), .DATA_W(16), .INDEX_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors = 0;
   int errors  = 0;

   // Main memory as seen by the responder, and the bench's own prediction of it.
   logic [15:0] mem_arr [256];
   logic [15:0] ref_mem [256];
   bit          hold_ack   = 1'b0;
   int          force_wait = -1;
   logic        log_we    [$];
   logic [7:0]  log_addr  [$];
   logic [15:0] log_wdata [$];

   bit          busy;
   int          wait_left;
   logic        tx_we;
   logic [7:0]  tx_addr;
   logic [15:0] tx_wdata;

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      busy      = 1'b0;
      wait_left = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mem_ack = 1'b0;
            busy    = 1'b0;
         end else begin
            if (mem_ack) begin
               mem_ack = 1'b0;
               busy    = 1'b0;
            end
            if (mem_req && !busy) begin
               busy      = 1'b1;
               tx_we     = mem_we;
               tx_addr   = mem_addr;
               tx_wdata  = mem_wdata;
               wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
            end else if (busy) begin
               vectors++;
               if (mem_req !== 1'b1 || mem_we !== tx_we || mem_addr !== tx_addr ||
                   (tx_we && mem_wdata !== tx_wdata)) begin
                  errors++;
                  $display("FAIL mem_stable: got req=%b we=%b addr=%h wdata=%h required req=1 we=%b addr=%h wdata=%h",
                           mem_req, mem_we, mem_addr, mem_wdata, tx_we, tx_addr, tx_wdata);
               end
            end
            if (busy && !hold_ack) begin
               if (wait_left == 0) begin
                  mem_ack = 1'b1;
                  if (tx_we) mem_arr[tx_addr] = tx_wdata;
                  else       mem_rdata = mem_arr[tx_addr];
                  log_we.push_back(tx_we);
                  log_addr.push_back(tx_addr);
                  log_wdata.push_back(tx_wdata);
               end else begin
                  wait_left--;
               end
            end
         end
      end
   end

   // Reference cache: each set is a recency list of at most two line addresses.
   logic [7:0]  mru_line [4];
   logic [7:0]  lru_line [4];
   int          nlines   [4];
   logic [15:0] cdata    [256];
   bit          cdirty   [256];
   int          m_hit, m_miss, m_wb;

   bit          last_hit;
   int          last_lat;
   logic [15:0] last_rdata;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) nlines[i] = 0;
      for (int i = 0; i < 256; i++) cdirty[i] = 1'b0;
      m_hit = 0; m_miss = 0; m_wb = 0;
   endtask

   task automatic do_req(input bit wr, input logic [7:0] a, input logic [15:0] wd);
      int          s, lat, t;
      bit          e_hit;
      logic [15:0] e_data;
      logic [7:0]  v;
      logic        ew [$];
      logic [7:0]  ea [$];
      logic [15:0] ed [$];
      s = int'(a[1:0]);
      e_hit = (nlines[s] >= 1 && mru_line[s] == a) || (nlines[s] == 2 && lru_line[s] == a);
      if (e_hit) begin
         m_hit++;
         if (wr) begin
            cdata[a]  = wd;
            cdirty[a] = 1'b1;
         end
         if (mru_line[s] != a) begin
            lru_line[s] = mru_line[s];
            mru_line[s] = a;
         end
      end else begin
         m_miss++;
         if (nlines[s] == 2) begin
            v = lru_line[s];
            if (cdirty[v]) begin
               ew.push_back(1'b1); ea.push_back(v); ed.push_back(cdata[v]);
               ref_mem[v] = cdata[v];
               m_wb++;
            end
            cdirty[v] = 1'b0;
            lru_line[s] = mru_line[s];
         end else if (nlines[s] == 1) begin
            lru_line[s] = mru_line[s];
            nlines[s] = 2;
         end else begin
            nlines[s] = 1;
         end
         mru_line[s] = a;
         ew.push_back(1'b0); ea.push_back(a); ed.push_back(16'h0);
         cdata[a]  = wr ? wd : ref_mem[a];
         cdirty[a] = wr;
      end
      e_data = cdata[a];

      @(negedge clk);
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      log_we.delete(); log_addr.delete(); log_wdata.delete();
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 16'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 200);

      vectors++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL resp_timeout: addr=%h got no resp_valid in %0d cycles, required a response", a, lat);
      end
      vectors++;
      if (resp_hit !== e_hit) begin
         errors++;
         $display("FAIL resp_hit: addr=%h got %b required %b", a, resp_hit, e_hit);
      end
      vectors++;
      if (resp_rdata !== e_data) begin
         errors++;
         $display("FAIL resp_rdata: addr=%h got %h required %h", a, resp_rdata, e_data);
      end
      if (e_hit) begin
         vectors++;
         if (lat != 2) begin
            errors++;
            $display("FAIL hit_latency: addr=%h got %0d required 2", a, lat);
         end
      end
      vectors++;
      if (log_we.size() != ew.size()) begin
         errors++;
         $display("FAIL mem_tx_count: addr=%h got %0d required %0d", a, log_we.size(), ew.size());
      end else begin
         for (int i = 0; i < ew.size(); i++) begin
            vectors++;
            if (log_we[i] !== ew[i] || log_addr[i] !== ea[i] || (ew[i] && log_wdata[i] !== ed[i])) begin
               errors++;
               $display("FAIL mem_tx[%0d]: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                        i, log_we[i], log_addr[i], log_wdata[i], ew[i], ea[i], ed[i]);
            end
         end
      end
      vectors++;
      if (hit_cnt !== 16'(m_hit) || miss_cnt !== 16'(m_miss) || wb_cnt !== 16'(m_wb)) begin
         errors++;
         $display("FAIL counters: got hit=%0d miss=%0d wb=%0d required hit=%0d miss=%0d wb=%0d",
                  hit_cnt, miss_cnt, wb_cnt, m_hit, m_miss, m_wb);
      end
      last_hit   = resp_hit;
      last_lat   = lat;
      last_rdata = resp_rdata;
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL resp_pulse: got resp_valid=%b req_ready=%b required 0 1", resp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({req_ready, resp_valid, resp_hit, mem_req, mem_we} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got ready/rv/hit/mreq/mwe=%b required 10000",
                  {req_ready, resp_valid, resp_hit, mem_req, mem_we});
      end
      vectors++;
      if (resp_rdata !== 16'h0 || mem_addr !== 8'h0 || mem_wdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h maddr=%h mwdata=%h required 0 0 0", resp_rdata, mem_addr, mem_wdata);
      end
      vectors++;
      if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || wb_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_counters: got %0d %0d %0d required 0 0 0", hit_cnt, miss_cnt, wb_cnt);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_miss_fill();
      mem_arr[8'h05] = 16'hBEEF;
      ref_mem[8'h05] = 16'hBEEF;
      force_wait = 3;
      do_req(1'b0, 8'h05, 16'h0);
      force_wait = -1;
      vectors++;
      if (last_hit !== 1'b0 || last_rdata !== 16'hBEEF || miss_cnt !== 16'd1) begin
         errors++;
         $display("FAIL first_miss: got hit=%b rdata=%h miss_cnt=%0d required 0 beef 1", last_hit, last_rdata, miss_cnt);
      end
   endtask

   task automatic test_hit();
      do_req(1'b0, 8'h05, 16'h0);
      vectors++;
      if (last_hit !== 1'b1 || last_rdata !== 16'hBEEF || hit_cnt !== 16'd1 || last_lat != 2) begin
         errors++;
         $display("FAIL repeat_hit: got hit=%b rdata=%h hit_cnt=%0d lat=%0d required 1 beef 1 2",
                  last_hit, last_rdata, hit_cnt, last_lat);
      end
   endtask

   task automatic test_writeback();
      force_wait = 0;
      do_req(1'b1, 8'h05, 16'h1234);
      do_req(1'b0, 8'h09, 16'h0);
      do_req(1'b0, 8'h0D, 16'h0);
      force_wait = -1;
      vectors++;
      if (log_addr.size() != 2 || log_we[0] !== 1'b1 || log_addr[0] !== 8'h05 ||
          log_wdata[0] !== 16'h1234 || log_addr[1] !== 8'h0D || wb_cnt !== 16'd1) begin
         errors++;
         $display("FAIL dirty_evict: got %0d txs, wb_cnt=%0d required wb 05/1234 then fill 0d, wb_cnt=1",
                  log_addr.size(), wb_cnt);
      end
   endtask

   task automatic test_lru();
      do_req(1'b0, 8'h02, 16'h0);
      do_req(1'b0, 8'h06, 16'h0);
      do_req(1'b0, 8'h02, 16'h0);
      vectors++;
      if (last_hit !== 1'b1) begin
         errors++;
         $display("FAIL lru_touch: got hit=%b required 1", last_hit);
      end
      do_req(1'b0, 8'h0A, 16'h0);
      do_req(1'b0, 8'h02, 16'h0);
      vectors++;
      if (last_hit !== 1'b1) begin
         errors++;
         $display("FAIL lru_keep: got hit=%b required 1", last_hit);
      end
      do_req(1'b0, 8'h06, 16'h0);
      vectors++;
      if (last_hit !== 1'b0) begin
         errors++;
         $display("FAIL lru_evicted: got hit=%b required 0", last_hit);
      end
   endtask

   task automatic test_store_miss();
      logic [15:0] wd;
      wd = 16'($urandom);
      do_req(1'b1, 8'h03, wd);
      vectors++;
      if (last_hit !== 1'b0 || last_rdata !== wd || log_addr.size() != 1 ||
          log_we[0] !== 1'b0 || log_addr[0] !== 8'h03) begin
         errors++;
         $display("FAIL store_miss: got hit=%b rdata=%h required 0 %h with one fill at 03", last_hit, last_rdata, wd);
      end
      do_req(1'b0, 8'h07, 16'h0);
      do_req(1'b0, 8'h0B, 16'h0);
      vectors++;
      if (log_addr.size() != 2 || log_we[0] !== 1'b1 || log_addr[0] !== 8'h03 || log_wdata[0] !== wd) begin
         errors++;
         $display("FAIL store_miss_wb: got %0d txs required write-back of %h at 03", log_addr.size(), wd);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++)
         do_req(1'($urandom), 8'($urandom_range(0, 31)), 16'($urandom));
   endtask

   task automatic test_reset_mid();
      int t;
      do_req(1'b1, 8'h0F, 16'($urandom));
      do_req(1'b1, 8'h13, 16'($urandom));
      hold_ack = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h17; req_wdata = '0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      t = 0;
      while (!(mem_req && mem_we) && t < 20) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
         errors++;
         $display("FAIL abort_setup: got mem_req=%b mem_we=%b required 1 1", mem_req, mem_we);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_async: got mem_req=%b req_ready=%b required 0 1", mem_req, req_ready);
      end
      hold_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      vectors++;
      if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || wb_cnt !== 16'h0) begin
         errors++;
         $display("FAIL abort_counters: got %0d %0d %0d required 0 0 0", hit_cnt, miss_cnt, wb_cnt);
      end
      do_req(1'b0, 8'h17, 16'h0);
      vectors++;
      if (last_hit !== 1'b0 || miss_cnt !== 16'd1) begin
         errors++;
         $display("FAIL abort_invalid: got hit=%b miss_cnt=%0d required 0 1", last_hit, miss_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 16'($urandom);
         ref_mem[i] = mem_arr[i];
      end
      test_reset();
      test_miss_fill();
      test_hit();
      test_writeback();
      test_lru();
      test_store_miss();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
